// File: rtl/cracker_def.sv
// Opcode/XO constants, FSM encoding and decode record shared by the instruction cracker.
// Pure definitions; no logic, no latency, no flow control.
package cracker_def;

    localparam logic [5:0] OP_ADDI  = 6'd14;
    localparam logic [5:0] OP_X     = 6'd31;
    localparam logic [5:0] OP_LWZ   = 6'd32;
    localparam logic [5:0] OP_LWZU  = 6'd33;
    localparam logic [5:0] OP_LBZ   = 6'd34;
    localparam logic [5:0] OP_LBZU  = 6'd35;
    localparam logic [5:0] OP_STW   = 6'd36;
    localparam logic [5:0] OP_STWU  = 6'd37;
    localparam logic [5:0] OP_STB   = 6'd38;
    localparam logic [5:0] OP_STBU  = 6'd39;
    localparam logic [5:0] OP_LHZ   = 6'd40;
    localparam logic [5:0] OP_LHZU  = 6'd41;
    localparam logic [5:0] OP_LHA   = 6'd42;
    localparam logic [5:0] OP_LHAU  = 6'd43;
    localparam logic [5:0] OP_STH   = 6'd44;
    localparam logic [5:0] OP_STHU  = 6'd45;
    localparam logic [5:0] OP_LMW   = 6'd46;
    localparam logic [5:0] OP_STMW  = 6'd47;
    localparam logic [5:0] OP_DS_LD = 6'd58;
    localparam logic [5:0] OP_DS_ST = 6'd62;

    localparam logic [1:0] DS_XO_BASE = 2'd0;
    localparam logic [1:0] DS_XO_UPD  = 2'd1;

    localparam logic [9:0] XO_ADD    = 10'd266;
    localparam logic [9:0] XO_LDX    = 10'd21;
    localparam logic [9:0] XO_LDUX   = 10'd53;
    localparam logic [9:0] XO_LWZX   = 10'd23;
    localparam logic [9:0] XO_LWZUX  = 10'd55;
    localparam logic [9:0] XO_LBZX   = 10'd87;
    localparam logic [9:0] XO_LBZUX  = 10'd119;
    localparam logic [9:0] XO_STDX   = 10'd149;
    localparam logic [9:0] XO_STDUX  = 10'd181;
    localparam logic [9:0] XO_STWX   = 10'd151;
    localparam logic [9:0] XO_STWUX  = 10'd183;
    localparam logic [9:0] XO_STBX   = 10'd215;
    localparam logic [9:0] XO_STBUX  = 10'd247;
    localparam logic [9:0] XO_LHZX   = 10'd279;
    localparam logic [9:0] XO_LHZUX  = 10'd311;
    localparam logic [9:0] XO_LHAX   = 10'd343;
    localparam logic [9:0] XO_LHAUX  = 10'd375;
    localparam logic [9:0] XO_STHX   = 10'd407;
    localparam logic [9:0] XO_STHUX  = 10'd439;

    typedef enum logic [1:0] {ST_IDLE, ST_UPD2, ST_MULTI} crack_state_t;
    typedef enum logic [1:0] {CK_PASS, CK_UPD, CK_MULTI} crack_kind_t;

    typedef struct packed {
        crack_kind_t kind;
        logic        illegal;
        logic [31:0] mem_uop;
        logic [31:0] upd_uop;
    } crack_dec_t;

    // {hit, is_load, base opcode} for D-form update opcodes
    function automatic logic [7:0] d_upd_map(input logic [5:0] op);
        case (op)
            OP_LWZU: return {2'b11, OP_LWZ};
            OP_LBZU: return {2'b11, OP_LBZ};
            OP_LHZU: return {2'b11, OP_LHZ};
            OP_LHAU: return {2'b11, OP_LHA};
            OP_STWU: return {2'b10, OP_STW};
            OP_STBU: return {2'b10, OP_STB};
            OP_STHU: return {2'b10, OP_STH};
            default: return 8'd0;
        endcase
    endfunction

    // {hit, is_load, base XO} for X-form update extended opcodes
    function automatic logic [11:0] x_upd_map(input logic [9:0] xo);
        case (xo)
            XO_LWZUX: return {2'b11, XO_LWZX};
            XO_LBZUX: return {2'b11, XO_LBZX};
            XO_LHZUX: return {2'b11, XO_LHZX};
            XO_LHAUX: return {2'b11, XO_LHAX};
            XO_LDUX:  return {2'b11, XO_LDX};
            XO_STWUX: return {2'b10, XO_STWX};
            XO_STBUX: return {2'b10, XO_STBX};
            XO_STHUX: return {2'b10, XO_STHX};
            XO_STDUX: return {2'b10, XO_STDX};
            default:  return 12'd0;
        endcase
    endfunction

endpackage

// File: rtl/insn_crack_decode.sv
// Classifies an instruction and builds its base-form uop, update uop and lmw/stmw remaining count.
// Combinational, zero latency; no flow control. CRACK_ILLEGAL_CHK_EN enables invalid-form detection.
module insn_crack_decode
    import cracker_def::*;
#(
    parameter int GPR_NUM = 32,
    parameter int CNT_W   = 5
) (
    input  logic [31:0]      insn,
    output crack_dec_t       dec,
    output logic [CNT_W-1:0] mw_rem
);

`ifdef CRACK_ILLEGAL_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic [5:0]  op;
    logic [4:0]  rt, ra, rb;
    logic [15:0] d;
    logic [9:0]  xo;
    logic [7:0]  dmap;
    logic [11:0] xmap;
    logic        ds_upd, is_upd, ld_upd, is_mw, illegal;

    assign op = insn[31:26];
    assign rt = insn[25:21];
    assign ra = insn[20:16];
    assign rb = insn[15:11];
    assign d  = insn[15:0];
    assign xo = insn[10:1];

    assign dmap   = d_upd_map(op);
    assign xmap   = (op == OP_X) ? x_upd_map(xo) : 12'd0;
    assign ds_upd = ((op == OP_DS_LD) || (op == OP_DS_ST)) && (insn[1:0] == DS_XO_UPD);
    assign is_upd = dmap[7] || xmap[11] || ds_upd;
    assign ld_upd = (dmap[7] && dmap[6]) || (xmap[11] && xmap[10]) || (ds_upd && op == OP_DS_LD);
    assign is_mw  = (op == OP_LMW) || (op == OP_STMW);

    assign illegal = CHK_EN && ((is_upd && ra == 5'd0) ||
                                (ld_upd && ra == rt) ||
                                (op == OP_LMW && ra >= rt && 32'(ra) < GPR_NUM));

    // First word is RT itself; the count excludes it so it fits in clog2(GPR_NUM) bits.
    assign mw_rem = (32'(rt) < GPR_NUM) ? CNT_W'(GPR_NUM - 1 - int'(rt)) : '0;

    always_comb begin
        dec         = '0;
        dec.kind    = CK_PASS;
        dec.illegal = illegal;
        dec.mem_uop = insn;
        dec.upd_uop = insn;
        if (dmap[7]) begin
            dec.mem_uop = {dmap[5:0], insn[25:0]};
            dec.upd_uop = {OP_ADDI, ra, ra, d};
        end else if (ds_upd) begin
            dec.mem_uop = {insn[31:2], DS_XO_BASE};
            dec.upd_uop = {OP_ADDI, ra, ra, d[15:2], 2'b00};
        end else if (xmap[11]) begin
            dec.mem_uop = {insn[31:11], xmap[9:0], insn[0]};
            dec.upd_uop = {OP_X, ra, ra, rb, XO_ADD, 1'b0};
        end else if (is_mw) begin
            dec.mem_uop = {(op == OP_LMW) ? OP_LWZ : OP_STW, insn[25:0]};
        end
        if (!illegal) begin
            if (is_upd)
                dec.kind = CK_UPD;
            else if (is_mw)
                dec.kind = CK_MULTI;
        end
    end

endmodule

// File: rtl/insn_cracker.sv
// Cracks update-form loads/stores and lmw/stmw into simple uops between fetch and decode.
// Latency 1 cycle to first uop, then one uop per accepted output; in_ready only in IDLE with a free output register.
// Output register stalls while out_valid & !out_ready. CRACK_ILLEGAL_CHK_EN flags invalid forms instead of cracking.
module insn_cracker
    import cracker_def::*;
#(
    parameter int INSTR_WIDTH   = 32,
    parameter int PC_WIDTH      = 32,
    parameter int GPR_NUM       = 32,
    parameter int MW_STRIDE     = 4,
    parameter int UPD_MEM_FIRST = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_insn,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_uop,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   out_illegal
);

    localparam int          CNT_W   = (GPR_NUM > 1) ? $clog2(GPR_NUM) : 1;
    localparam logic [15:0] MW_STEP = 16'(MW_STRIDE);

    crack_state_t     state;
    crack_dec_t       dec;
    logic [CNT_W-1:0] mw_rem, cnt;
    logic [31:0]      pend_uop;
    logic [5:0]       mw_op;
    logic [4:0]       mw_reg, mw_ra;
    logic [15:0]      mw_disp;
    logic             in_fire;

    insn_crack_decode #(
        .GPR_NUM (GPR_NUM),
        .CNT_W   (CNT_W)
    ) u_decode (
        .insn   (32'(in_insn)),
        .dec    (dec),
        .mw_rem (mw_rem)
    );

    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            out_uop     <= '0;
            out_pc      <= '0;
            out_first   <= 1'b0;
            out_last    <= 1'b0;
            out_illegal <= 1'b0;
            cnt         <= '0;
            pend_uop    <= '0;
            mw_op       <= '0;
            mw_reg      <= '0;
            mw_ra       <= '0;
            mw_disp     <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_fire) begin
                        out_valid   <= 1'b1;
                        out_pc      <= in_pc;
                        out_first   <= 1'b1;
                        out_illegal <= dec.illegal;
                        case (dec.kind)
                            CK_UPD: begin
                                out_uop  <= INSTR_WIDTH'((UPD_MEM_FIRST != 0) ? dec.mem_uop : dec.upd_uop);
                                pend_uop <= (UPD_MEM_FIRST != 0) ? dec.upd_uop : dec.mem_uop;
                                out_last <= 1'b0;
                                state    <= ST_UPD2;
                            end
                            CK_MULTI: begin
                                // mw_reg/mw_disp always hold the fields of the next uop to emit
                                out_uop  <= INSTR_WIDTH'(dec.mem_uop);
                                out_last <= (mw_rem == '0);
                                cnt      <= mw_rem;
                                mw_op    <= dec.mem_uop[31:26];
                                mw_reg   <= dec.mem_uop[25:21] + 5'd1;
                                mw_ra    <= dec.mem_uop[20:16];
                                mw_disp  <= dec.mem_uop[15:0] + MW_STEP;
                                if (mw_rem != '0)
                                    state <= ST_MULTI;
                            end
                            default: begin
                                out_uop  <= in_insn;
                                out_last <= 1'b1;
                            end
                        endcase
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                ST_UPD2: begin
                    if (out_ready) begin
                        out_uop     <= INSTR_WIDTH'(pend_uop);
                        out_first   <= 1'b0;
                        out_last    <= 1'b1;
                        out_illegal <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_MULTI: begin
                    if (out_ready) begin
                        out_uop     <= INSTR_WIDTH'({mw_op, mw_reg, mw_ra, mw_disp});
                        out_first   <= 1'b0;
                        out_last    <= (cnt == CNT_W'(1));
                        out_illegal <= 1'b0;
                        cnt         <= cnt - CNT_W'(1);
                        mw_reg      <= mw_reg + 5'd1;
                        mw_disp     <= mw_disp + MW_STEP;
                        if (cnt == CNT_W'(1))
                            state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/insn_cracker.md
Name: insn_cracker

Overview:
- Pipelined successor to the front-end instruction converter. Cracks PowerPC update-form loads/stores (D, DS and X forms) and lmw/stmw into simple micro-ops.
- Sits between the fetch buffer and decode, with valid/ready handshakes on both sides.
- Replaces the PC-compare/stall scheme with an explicit FSM, registered output, flush support and per-uop first/last tags.
- Parametrised in width, register-file size and multiple-word stride.

Parameters:
- INSTR_WIDTH, 32: instruction/uop width.
- PC_WIDTH, 32: PC width.
- GPR_NUM, 32: GPR count; bounds the lmw/stmw sequence.
- MW_STRIDE, 4: byte displacement step between lmw/stmw words.
- UPD_MEM_FIRST, 1: 1 = memory uop before the address-update uop; 0 = update uop first.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard the in-flight instruction and the output register
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  cracker accepts this cycle
- in_insn  in  INSTR_WIDTH  raw instruction
- in_pc  in  PC_WIDTH  instruction PC
- out_valid  out  1  uop valid
- out_ready  in  1  decode accepts the uop
- out_uop  out  INSTR_WIDTH  micro-op
- out_pc  out  PC_WIDTH  PC of the parent instruction
- out_first  out  1  first uop of the parent
- out_last  out  1  last uop of the parent
- out_illegal  out  1  invalid-form flag (optional feature only; tied 0 otherwise)

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_valid, out_first, out_last and out_illegal = 0; out_uop and out_pc = 0; FSM = IDLE; counters = 0.
- Handshakes: transfer on in_valid&in_ready and on out_valid&out_ready. in_ready = (state==IDLE) & (!out_valid | out_ready). The output register holds stable while out_valid & !out_ready.
- Latency: 1 cycle from input acceptance to the first uop. Each further uop follows 1 cycle after the previous one is accepted.
- Non-cracked instruction: passes through unchanged; out_first = out_last = 1.
- Update forms (lbzu, lhzu, lhau, lwzu, ldu, stbu, sthu, stwu, stdu, and the X-form ...ux variants): two uops.
  - Memory uop: base opcode/XO, same RT/RS, RA, D/DS/RB.
  - Update uop: addi RA,RA,D (ldu/stdu: displacement DS||0b00), or add RA,RA,RB for X forms.
  - Order set by UPD_MEM_FIRST.
- lmw/stmw: N = GPR_NUM - RT uops, each lwz/stw rK,Dk(RA).
  - K runs RT..GPR_NUM-1.
  - Dk = D + k*MW_STRIDE, truncated to 16 bits (displacement wraps, no carry into RA).
  - RT = GPR_NUM-1 gives a single uop with first = last = 1.
- FSM:
  - IDLE -> UPD2 after accepting an update form.
  - IDLE -> MULTI after accepting lmw/stmw with N > 1.
  - UPD2 -> IDLE when the second uop loads into the output register.
  - MULTI keeps a down-counter (width clog2(GPR_NUM)), a register index and a displacement register. It loads the next uop on each output acceptance and returns to IDLE once the last uop is loaded.
- flush: next edge sets out_valid = 0 and FSM = IDLE and clears counters. Flush beats a simultaneous input acceptance; that instruction is dropped.
- Simultaneous rst and flush: rst wins; the result is identical.
- out_pc carries the parent PC on every uop.

Optional Feature:
- Macro: CRACK_ILLEGAL_CHK_EN.
- Defined: these invalid forms emit a single uop (original instruction, first = last = 1) with out_illegal = 1 and are not cracked:
  - any update form with RA = 0;
  - a load-update with RA == RT;
  - lmw with RA in [RT, GPR_NUM-1].
- Undefined: no checking; out_illegal is constant 0; such forms are cracked normally.

Decomposition:
- Shared package/include `cracker_def`:
  - opcode/XO constants for update forms and their base forms, plus addi (14), add (31/266), lmw (46), stmw (47);
  - FSM state encoding.
- Natural sub-module: `insn_crack_decode`, combinational. Classifies the instruction and produces the base-form uop, the update uop and N.
- The FSM and output register stay in insn_cracker.

Test Plan:
- lwzu r5,8(r3) = 0x84A30008 with out_ready = 1 -> 0x80A30008 (first = 1), then 0x38630008 (last = 1) on consecutive cycles; in_ready low during UPD2.
- lmw r29,16(r1) = 0xBBA10010 -> 0x83A10010, 0x83C10014, 0x83E10018; first only on the 1st, last only on the 3rd; same out_pc on all three.
- Passthrough add 0x7C632214 with out_ready held 0 for 3 cycles -> out_uop and out_valid stable; single uop with first = last = 1 once accepted.
- flush asserted after the 1st uop of lmw r28,0(r2) -> next cycle out_valid = 0, in_ready = 1; the next instruction is cracked cleanly from IDLE.
- lmw r31,0xFFFC(r4) -> single uop 0x83E4FFFC with first = last = 1; separately, a stmw sequence whose displacement passes 0xFFFC wraps to 0x0000.
- CRACK_ILLEGAL_CHK_EN on: lwzu r3,4(r3) = 0x84630004 -> single 0x84630004 with out_illegal = 1. With the macro off: cracked into two uops, out_illegal = 0.
